// File: rtl/timera_iv.sv
// timera_iv: Timer_A interrupt-vector responder; prioritises flags into TAxIV,
// issues one-cycle auto-clear pulses and drives the CCR0/IV interrupt lines.
module timera_iv #(
    parameter logic [15:0] TAnIV_OFFSET = 16'h012E,
    parameter int          NUM_CCR      = 3
) (
    input  logic               MCLK,
    input  logic               wTACLR,
    input  logic [15:0]        MAB,
    input  logic               MR,
    input  logic               MW,
    input  logic               BW,
    input  logic               wTAIFG,
    input  logic               wTAIE,
    input  logic [NUM_CCR-1:0] CCIFG,
    input  logic [NUM_CCR-1:0] CCIE,
    output logic               TAIFGclr,
    output logic [NUM_CCR-1:0] CCIFGclr,
    output logic               INT0,
    output logic               INT1,
    output logic [15:0]        MDBread
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t               r_state;
    logic [15:0]          r_snap;
    logic [15:0]          w_iv_live;
    logic [15:0]          w_value;
    logic [NUM_CCR-1:0]   w_cc_clr;
    logic                 w_hit_word;
    logic                 w_hit_lo;
    logic                 w_hit_hi;
    logic                 w_hit;
    logic                 w_rd;
    logic                 w_rd_clr;
    logic                 w_unused_mw;
    // Scan downward so the lowest-numbered pending channel wins.
    always_comb begin
        w_iv_live = (wTAIFG && wTAIE) ? 16'h000E : 16'h0000;
        for (int n = NUM_CCR - 1; n >= 1; n--)
            if (CCIFG[n] && CCIE[n]) w_iv_live = 16'(2 * n);
    end
    always_comb begin
        w_cc_clr = '0;
        for (int n = 1; n < NUM_CCR; n++)
            w_cc_clr[n] = (w_iv_live == 16'(2 * n));
    end
    assign w_hit_word  = !BW && ((MAB & ~16'h0001) == TAnIV_OFFSET);
    assign w_hit_lo    = BW && (MAB == TAnIV_OFFSET);
    assign w_hit_hi    = BW && (MAB == TAnIV_OFFSET + 16'd1);
    assign w_hit       = w_hit_word || w_hit_lo || w_hit_hi;
    assign w_rd        = w_hit && MR;
    assign w_rd_clr    = w_rd && !w_hit_hi;
    assign w_unused_mw = MW;
    assign INT0        = CCIFG[0] && CCIE[0];
    assign INT1        = (w_iv_live != 16'h0000);
    assign w_value     = (r_state == HOLD) ? r_snap : w_iv_live;
    assign MDBread     = !w_hit   ? 16'hzzzz :
                         w_hit_hi ? 16'h0000 :
                         w_hit_lo ? {8'h00, w_value[7:0]} : w_value;
    always_ff @(posedge MCLK or posedge wTACLR) begin
        if (wTACLR) begin
            r_state  <= IDLE;
            r_snap   <= '0;
            TAIFGclr <= 1'b0;
            CCIFGclr <= '0;
        end else if (r_state == IDLE) begin
            TAIFGclr <= w_rd_clr && (w_iv_live == 16'h000E);
            CCIFGclr <= w_rd_clr ? w_cc_clr : '0;
            if (w_rd_clr) begin
                r_state <= HOLD;
                r_snap  <= w_iv_live;
            end
        end else begin
            TAIFGclr <= 1'b0;
            CCIFGclr <= '0;
            if (!w_rd) r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_timera_iv.sv
// tb_timera_iv: directed and randomized checks of timera_iv against a behavioural model.
module tb_timera_iv;
    localparam int          N   = 3;
    localparam logic [15:0] OFF = 16'h012E;
    logic          MCLK = 1'b0;
    logic          wTACLR;
    logic [15:0]   MAB;
    logic          MR, MW, BW, wTAIFG, wTAIE;
    logic [N-1:0]  CCIFG, CCIE;
    logic          TAIFGclr, INT0, INT1;
    logic [N-1:0]  CCIFGclr;
    logic [15:0]   MDBread;
    int            n_cmp = 0;
    int            n_err = 0;
    timera_iv #(.TAnIV_OFFSET(OFF), .NUM_CCR(N)) dut (
        .MCLK(MCLK), .wTACLR(wTACLR), .MAB(MAB), .MR(MR), .MW(MW), .BW(BW),
        .wTAIFG(wTAIFG), .wTAIE(wTAIE), .CCIFG(CCIFG), .CCIE(CCIE),
        .TAIFGclr(TAIFGclr), .CCIFGclr(CCIFGclr), .INT0(INT0), .INT1(INT1),
        .MDBread(MDBread)
    );
    always #5 MCLK = ~MCLK;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask
    // Vector value from priority rules: lowest CCR n>=1 gives 2n, else overflow gives 14.
    function automatic logic [15:0] ref_iv(input logic [N-1:0] f, input logic [N-1:0] e,
                                           input logic tf, input logic te);
        for (int n = 1; n < N; n++)
            if (f[n] && e[n]) return 16'(2 * n);
        return (tf && te) ? 16'd14 : 16'd0;
    endfunction
    initial begin
        logic          m_hold;
        logic [15:0]   m_snap, iv, v, exp_bus;
        logic          hit, lo, hi, rd, exp_ta;
        logic [N-1:0]  exp_cc;
        int            r;
        wTACLR = 1'b1; MAB = 16'h0; MR = 0; MW = 0; BW = 0;
        wTAIFG = 0; wTAIE = 0; CCIFG = '0; CCIE = '0;
        #12;
        chk("rst_taclr", 16'(TAIFGclr), 16'h0);
        chk("rst_ccclr", 16'(CCIFGclr), 16'h0);
        wTACLR = 1'b0;
        tick();
        CCIFG = 3'b110; CCIE = 3'b110; wTAIFG = 1; wTAIE = 1;
        MAB = OFF; MR = 1; #1;
        chk("t1_bus", MDBread, 16'h0002);
        chk("t1_int1", 16'(INT1), 16'h1);
        tick();
        chk("t1_ccclr", 16'(CCIFGclr), 16'h0002);
        chk("t1_taclr", 16'(TAIFGclr), 16'h0);
        MR = 0; tick();
        chk("t1_ccclr_off", 16'(CCIFGclr), 16'h0);
        CCIFG = 0; CCIE = 0; wTAIFG = 1; wTAIE = 0; #1;
        chk("t2_int1", 16'(INT1), 16'h0);
        MR = 1; #1;
        chk("t2_bus0", MDBread, 16'h0000);
        tick();
        chk("t2_noclr", {15'h0, TAIFGclr} | 16'(CCIFGclr), 16'h0);
        MR = 0; tick();
        wTAIE = 1; MR = 1; #1;
        chk("t2_busE", MDBread, 16'h000E);
        tick();
        chk("t2_taclr", 16'(TAIFGclr), 16'h1);
        MR = 0; tick();
        chk("t2_taclr_off", 16'(TAIFGclr), 16'h0);
        wTAIE = 0; CCIFG = 3'b100; CCIE = 3'b100; MR = 1; #1;
        chk("t3_bus", MDBread, 16'h0004);
        tick();
        chk("t3_clr1", 16'(CCIFGclr), 16'h0004);
        CCIFG = 3'b110; CCIE = 3'b110; #1;
        chk("t3_hold_bus", MDBread, 16'h0004);
        chk("t3_int1", 16'(INT1), 16'h1);
        tick();
        chk("t3_clr2", 16'(CCIFGclr), 16'h0);
        tick();
        chk("t3_clr3", 16'(CCIFGclr), 16'h0);
        chk("t3_hold_bus2", MDBread, 16'h0004);
        MR = 0; tick();
        MR = 1; #1;
        chk("t3_next", MDBread, 16'h0002);
        MR = 0; tick();
        CCIFG = 3'b100; CCIE = 3'b100; BW = 1; MAB = OFF + 16'd1; MR = 1; #1;
        chk("t4_hi_bus", MDBread, 16'h0000);
        tick();
        chk("t4_hi_noclr", 16'(CCIFGclr), 16'h0);
        MR = 0; tick();
        MAB = OFF; MR = 1; #1;
        chk("t4_lo_bus", MDBread, 16'h0004);
        tick();
        chk("t4_lo_clr", 16'(CCIFGclr), 16'h0004);
        MR = 0; BW = 0; tick();
        MW = 1; tick();
        chk("t4_wr_noclr", 16'(CCIFGclr), 16'h0);
        MW = 0; MR = 1; tick();
        chk("t4_after_wr", 16'(CCIFGclr), 16'h0004);
        #2 wTACLR = 1; #1;
        chk("t5_async", 16'(CCIFGclr), 16'h0);
        wTACLR = 0;
        tick();
        chk("t5_reclear", 16'(CCIFGclr), 16'h0004);
        MR = 0; tick();
        CCIFG = 3'b001; CCIE = 3'b001; wTAIFG = 0; #1;
        chk("t6_int0", 16'(INT0), 16'h1);
        chk("t6_int1", 16'(INT1), 16'h0);
        MR = 1; #1;
        chk("t6_bus", MDBread, 16'h0000);
        tick();
        chk("t6_noclr", 16'(CCIFGclr), 16'h0);
        MR = 0; tick();
        m_hold = 0; m_snap = 0;
        for (int i = 0; i < 400; i++) begin
            CCIFG = N'($urandom); CCIE = N'($urandom);
            wTAIFG = 1'($urandom); wTAIE = 1'($urandom);
            r = $urandom_range(0, 3);
            MAB = (r == 0) ? OFF : (r == 1) ? OFF + 16'd1 : (r == 2) ? OFF + 16'd2 : 16'($urandom);
            BW = 1'($urandom); MR = ($urandom_range(0, 9) < 6); MW = 1'($urandom);
            #1;
            iv  = ref_iv(CCIFG, CCIE, wTAIFG, wTAIE);
            v   = m_hold ? m_snap : iv;
            lo  = BW && MAB == OFF;
            hi  = BW && MAB == OFF + 16'd1;
            hit = lo || hi || (!BW && MAB[15:1] == OFF[15:1]);
            rd  = hit && MR;
            exp_bus = hi ? 16'h0 : lo ? {8'h0, v[7:0]} : v;
            if (hit) chk("rnd_bus", MDBread, exp_bus);
            chk("rnd_int", {14'h0, INT1, INT0}, {14'h0, iv != 0, CCIFG[0] & CCIE[0]});
            exp_ta = 0; exp_cc = '0;
            if (!m_hold && rd && !hi) begin
                exp_ta = (iv == 16'd14);
                if (iv != 0 && iv != 16'd14) exp_cc = N'(1 << (iv / 2));
                m_hold = 1; m_snap = iv;
            end else if (m_hold && !rd) m_hold = 0;
            tick();
            chk("rnd_clr", {12'h0, TAIFGclr, CCIFGclr}, {12'h0, exp_ta, exp_cc});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
